// File: rtl/pmul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pmul_arbiter_if
// Description : Bundles the two-requester request/response channels and the
//               point-multiplier core channel of pmul_arbiter.
//               slave  : arbiter side (drives req_ready, rsp_*, core_in/op).
//               master : environment side (requesters plus the core).
//               Ports  : req_valid/req_ready/req_Px/req_Py/req_k (2 lanes
//                        packed lane i at [i*WIDTH +: WIDTH]), rsp_valid/
//                        rsp_ready (2 lanes), rsp_Rx/rsp_Ry (shared),
//                        core_in_valid/core_Px/core_Py/core_k,
//                        core_out_valid/core_Rx/core_Ry.
// Revision    : 1.0 - initial release
// ============================================================================
interface pmul_arbiter_if #(
    parameter int WIDTH = 256
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_Px;
    logic [2*WIDTH-1:0] req_Py;
    logic [2*WIDTH-1:0] req_k;

    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_Rx;
    logic [WIDTH-1:0]   rsp_Ry;

    logic               core_in_valid;
    logic [WIDTH-1:0]   core_Px;
    logic [WIDTH-1:0]   core_Py;
    logic [WIDTH-1:0]   core_k;
    logic               core_out_valid;
    logic [WIDTH-1:0]   core_Rx;
    logic [WIDTH-1:0]   core_Ry;

    modport slave (
        input  req_valid, req_Px, req_Py, req_k,
        output req_ready,
        output rsp_valid, rsp_Rx, rsp_Ry,
        input  rsp_ready,
        output core_in_valid, core_Px, core_Py, core_k,
        input  core_out_valid, core_Rx, core_Ry
    );

    modport master (
        output req_valid, req_Px, req_Py, req_k,
        input  req_ready,
        input  rsp_valid, rsp_Rx, rsp_Ry,
        output rsp_ready,
        input  core_in_valid, core_Px, core_Py, core_k,
        output core_out_valid, core_Rx, core_Ry
    );
endinterface
`default_nettype wire

// File: rtl/pmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmul_arbiter
// Description : Round-robin arbiter sharing one point-multiplier core between
//               two requesters, one operation in flight at a time, with a
//               per-operation core timeout.
//               clk         : clock, rising edge
//               rst_n       : asynchronous active-low reset
//               bus         : pmul_arbiter_if.slave (requests, responses, core)
//               busy        : FSM not idle
//               timeout_err : sticky, set when the core fails to answer
// Revision    : 1.0 - initial release
// ============================================================================
module pmul_arbiter #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 20000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pmul_arbiter_if.slave      bus,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam int               c_CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_rr_ptr;
    logic             r_grant;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_px;
    logic [WIDTH-1:0] r_py;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_ry;

    logic             w_any_req;
    logic             w_grant;
    logic             w_accept;
    logic             w_cnt_last;
    logic             w_rsp_done;

    // Favour the round-robin pointer; fall back to the other lane only if
    // the favoured one is idle.
    assign w_any_req  = |bus.req_valid;
    assign w_grant    = bus.req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_accept   = (r_state == c_IDLE) && w_any_req;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_rsp_done = (r_state == c_RESP) && bus.rsp_ready[r_grant];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_next = c_ISSUE;
            c_ISSUE: w_next = c_WAIT;
            c_WAIT:  if (bus.core_out_valid || w_cnt_last) w_next = c_RESP;
            c_RESP:  if (bus.rsp_ready[r_grant]) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy              = (r_state != c_IDLE);
        bus.core_in_valid = (r_state == c_ISSUE);
        bus.rsp_valid     = 2'b00;
        bus.req_ready     = 2'b00;
        if (r_state == c_RESP) begin
            bus.rsp_valid[r_grant] = 1'b1;
        end
        // Qualified with rst_n so every output reads 0 while reset is held,
        // even though req_ready is combinational from req_valid.
        if (w_accept && rst_n) begin
            bus.req_ready[w_grant] = 1'b1;
        end
        bus.core_Px = r_px;
        bus.core_Py = r_py;
        bus.core_k  = r_k;
        bus.rsp_Rx  = r_rx;
        bus.rsp_Ry  = r_ry;
    end

    // Operand, result, grant, pointer, counter and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= 1'b0;
            r_grant     <= 1'b0;
            r_cnt       <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_k         <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant;
                r_px    <= w_grant ? bus.req_Px[2*WIDTH-1:WIDTH] : bus.req_Px[WIDTH-1:0];
                r_py    <= w_grant ? bus.req_Py[2*WIDTH-1:WIDTH] : bus.req_Py[WIDTH-1:0];
                r_k     <= w_grant ? bus.req_k[2*WIDTH-1:WIDTH]  : bus.req_k[WIDTH-1:0];
            end
            if (r_state == c_ISSUE) begin
                r_cnt <= '0;
            end
            if (r_state == c_WAIT) begin
                // A core answer in the final allowed cycle wins over timeout.
                if (bus.core_out_valid) begin
                    r_rx <= bus.core_Rx;
                    r_ry <= bus.core_Ry;
                end else if (w_cnt_last) begin
                    r_rx        <= '0;
                    r_ry        <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
            if (w_rsp_done) begin
                r_rr_ptr <= ~r_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmul_arbiter
// Description : Self-checking bench for pmul_arbiter. The reference model
//               tracks which requester was served last and whether a timeout
//               has occurred since reset; the bench also plays the core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmul_arbiter;

    localparam int W   = 32;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    logic busy;
    logic timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   last_served;
    logic exp_terr;
    logic [W-1:0] px [2];
    logic [W-1:0] py [2];
    logic [W-1:0] pk [2];

    pmul_arbiter_if #(.WIDTH(W)) bus ();

    pmul_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh(input int g);
        return (g != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        bus.req_Px = {px[1], px[0]};
        bus.req_Py = {py[1], py[0]};
        bus.req_k  = {pk[1], pk[0]};
    endtask

    // Asserts reset at a negedge, checks outputs immediately, releases at a
    // later negedge; ends 1ns after that negedge.
    task automatic do_reset(input logic [1:0] held_req);
        @(negedge clk);
        bus.req_valid = held_req;
        rst_n = 1'b0;
        #1;
        chk("rst_busy",     W'(busy),              W'(0));
        chk("rst_terr",     W'(timeout_err),       W'(0));
        chk("rst_req_rdy",  W'(bus.req_ready),     W'(0));
        chk("rst_rsp_vld",  W'(bus.rsp_valid),     W'(0));
        chk("rst_core_in",  W'(bus.core_in_valid), W'(0));
        chk("rst_core_px",  bus.core_Px,           W'(0));
        chk("rst_rsp_rx",   bus.rsp_Rx,            W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_served = 1;
        exp_terr    = 1'b0;
        #1;
    endtask

    // One complete operation. Called 1ns after a negedge with the DUT idle.
    task automatic do_op(input logic [1:0] mask, input bit rnd, input int delay,
                         input int bp, input bit silent,
                         input logic [W-1:0] rx, input logic [W-1:0] ry);
        int g;
        logic [W-1:0] erx;
        logic [W-1:0] ery;
        for (int i = 0; i < 2; i++) begin
            if (rnd && mask[i] && !bus.req_valid[i]) begin
                px[i] = $urandom;
                py[i] = $urandom;
                pk[i] = $urandom;
            end
        end
        drive_req();
        bus.req_valid = mask;
        g = (mask == 2'b11) ? 1 - last_served : (mask[1] ? 1 : 0);
        #1;
        chk("req_ready", W'(bus.req_ready), W'(oh(g)));
        chk("idle_busy", W'(busy), W'(0));

        // Start cycle: the accepted requester withdraws, the other holds.
        @(negedge clk);
        bus.req_valid[g] = 1'b0;
        #1;
        chk("core_in_valid", W'(bus.core_in_valid), W'(1));
        chk("core_Px", bus.core_Px, px[g]);
        chk("core_Py", bus.core_Py, py[g]);
        chk("core_k",  bus.core_k,  pk[g]);
        chk("busy_op", W'(busy), W'(1));
        chk("req_ready_busy", W'(bus.req_ready), W'(0));

        if (silent) begin
            for (int i = 1; i <= TMO; i++) begin
                @(negedge clk);
                #1;
                chk("rsp_early", W'(bus.rsp_valid), W'(0));
                if (i == 1)   chk("core_in_pulse", W'(bus.core_in_valid), W'(0));
                if (i == TMO) chk("terr_pre", W'(timeout_err), W'(exp_terr));
            end
            erx = '0;
            ery = '0;
            exp_terr = 1'b1;
        end else begin
            for (int i = 1; i <= delay; i++) begin
                @(negedge clk);
                if (i == delay) begin
                    bus.core_out_valid = 1'b1;
                    bus.core_Rx = rx;
                    bus.core_Ry = ry;
                end
                #1;
                chk("rsp_early", W'(bus.rsp_valid), W'(0));
                if (i == 1) chk("core_in_pulse", W'(bus.core_in_valid), W'(0));
            end
            erx = rx;
            ery = ry;
        end

        // First response cycle; non-granted rsp_ready bit is asserted during
        // backpressure and must have no effect.
        @(negedge clk);
        bus.core_out_valid = 1'b0;
        bus.rsp_ready = (bp == 0) ? oh(g) : ~oh(g);
        #1;
        chk("rsp_valid", W'(bus.rsp_valid), W'(oh(g)));
        chk("rsp_Rx", bus.rsp_Rx, erx);
        chk("rsp_Ry", bus.rsp_Ry, ery);
        chk("terr", W'(timeout_err), W'(exp_terr));
        chk("core_Px_hold", bus.core_Px, px[g]);

        for (int i = 1; i <= bp; i++) begin
            @(negedge clk);
            // A stray core strobe while responding must be ignored.
            bus.core_out_valid = (i == 1);
            bus.core_Rx = ~erx;
            bus.core_Ry = ~ery;
            if (i == bp) bus.rsp_ready = oh(g);
            #1;
            chk("bp_rsp_valid", W'(bus.rsp_valid), W'(oh(g)));
            chk("bp_rsp_Rx", bus.rsp_Rx, erx);
            chk("bp_rsp_Ry", bus.rsp_Ry, ery);
            chk("bp_req_ready", W'(bus.req_ready), W'(0));
        end

        @(negedge clk);
        bus.core_out_valid = 1'b0;
        bus.rsp_ready = 2'b00;
        #1;
        chk("done_rsp_valid", W'(bus.rsp_valid), W'(0));
        chk("done_busy", W'(busy), W'(0));
        last_served = g;
    endtask

    initial begin
        bus.req_valid      = 2'b00;
        bus.req_Px         = '0;
        bus.req_Py         = '0;
        bus.req_k          = '0;
        bus.rsp_ready      = 2'b00;
        bus.core_out_valid = 1'b0;
        bus.core_Rx        = '0;
        bus.core_Ry        = '0;
        rst_n              = 1'b1;
        last_served        = 1;
        exp_terr           = 1'b0;
        for (int i = 0; i < 2; i++) begin
            px[i] = '0;
            py[i] = '0;
            pk[i] = '0;
        end

        // Single request with fixed operands and a 10-cycle core.
        do_reset(2'b00);
        px[0] = 32'd1;
        py[0] = 32'd2;
        pk[0] = 32'd3;
        do_op(2'b01, 1'b0, 10, 0, 1'b0, 32'hA, 32'hB);

        // Contention from reset: 0, 1, 0.
        do_reset(2'b11);
        do_op(2'b11, 1'b1, 3, 0, 1'b0, $urandom, $urandom);
        do_op(2'b11, 1'b1, 5, 1, 1'b0, $urandom, $urandom);
        do_op(2'b11, 1'b1, 2, 0, 1'b0, $urandom, $urandom);

        // Backpressure on requester 0 for 5 cycles.
        bus.req_valid = 2'b00;
        do_op(2'b01, 1'b1, 4, 5, 1'b0, $urandom, $urandom);

        // Core answers in the last allowed cycle: no error.
        do_op(2'b10, 1'b1, TMO, 0, 1'b0, $urandom, $urandom);

        // Silent core, then a good operation with the flag still set.
        do_op(2'b01, 1'b1, 0, 2, 1'b1, '0, '0);
        do_op(2'b10, 1'b1, 6, 0, 1'b0, $urandom, $urandom);

        // Reset while waiting on the core; late core strobe ignored.
        px[0] = $urandom;
        py[0] = $urandom;
        pk[0] = $urandom;
        drive_req();
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("rw_core_in", W'(bus.core_in_valid), W'(1));
        repeat (3) @(negedge clk);
        #1;
        chk("rw_busy", W'(busy), W'(1));
        do_reset(2'b00);
        @(negedge clk);
        bus.core_out_valid = 1'b1;
        bus.core_Rx = $urandom;
        bus.core_Ry = $urandom;
        @(negedge clk);
        bus.core_out_valid = 1'b0;
        #1;
        chk("rw_rsp_valid", W'(bus.rsp_valid), W'(0));
        chk("rw_busy_after", W'(busy), W'(0));
        chk("rw_rsp_Rx", bus.rsp_Rx, W'(0));
        chk("rw_terr", W'(timeout_err), W'(0));
        do_op(2'b01, 1'b1, 7, 0, 1'b0, $urandom, $urandom);

        // Randomized traffic.
        for (int n = 0; n < 10; n++) begin
            do_op(2'($urandom_range(1, 3)), 1'b1, $urandom_range(1, TMO), $urandom_range(0, 3),
                  1'b0, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmul_arbiter.md
PMUL_ARBITER -- requirements
Module: pmul_arbiter

Interface
REQ-001 Parameter WIDTH, default 256, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 20000, maximum core cycles allowed per operation (must be >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; handshake = req_valid[i] & req_ready[i].
REQ-007 req_Px  input  2*WIDTH  base-point x; requester i at [i*WIDTH +: WIDTH].
REQ-008 req_Py  input  2*WIDTH  base-point y, same packing.
REQ-009 req_k  input  2*WIDTH  scalar, same packing.
REQ-010 rsp_valid  output  2  per-requester result valid.
REQ-011 rsp_ready  input  2  per-requester result consume.
REQ-012 rsp_Rx  output  WIDTH  result x, shared, qualified by rsp_valid.
REQ-013 rsp_Ry  output  WIDTH  result y, shared, qualified by rsp_valid.
REQ-014 core_in_valid  output  1  start pulse to point-multiplier core.
REQ-015 core_Px / core_Py / core_k  output  WIDTH each  operands to core.
REQ-016 core_out_valid  input  1  core result strobe.
REQ-017 core_Rx / core_Ry  input  WIDTH each  core result.
REQ-018 busy  output  1  high when state != IDLE.
REQ-019 timeout_err  output  1  sticky flag, set on core timeout.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; one core operation in flight at most.
REQ-021 IDLE: grant g = rr_ptr if req_valid[rr_ptr], else other requester if its req_valid is high; req_ready[g] combinationally high in IDLE only; req_ready never high for both bits.
REQ-022 On handshake: latch req_Px/Py/k slice g into operand registers, latch g, go ISSUE.
REQ-023 ISSUE: core_in_valid = 1 for exactly one cycle, go WAIT; core_Px/Py/k driven from operand registers, stable from ISSUE until return to IDLE.
REQ-024 WAIT: cycle counter starts at 0 on entry, increments each cycle; on core_out_valid latch core_Rx/Ry into result registers, go RESP.
REQ-025 WAIT: if counter reaches TIMEOUT-1 without core_out_valid, set timeout_err, load result registers with 0, go RESP; core_out_valid in that same cycle takes precedence (no error).
REQ-026 core_out_valid outside WAIT ignored; no state or result change.
REQ-027 RESP: rsp_valid[g] = 1, rsp_Rx/Ry = result registers, held stable until rsp_ready[g]; on that cycle rr_ptr <= ~g, go IDLE.
REQ-028 Latency: accept in cycle T -> core_in_valid in T+1; core_out_valid in cycle C -> rsp_valid[g] from C+1.
REQ-029 Requester not granted sees req_ready=0 and shall hold its request; no request is dropped; each requester served at most once per two operations while both pending.
REQ-030 rsp_ready on non-granted bit or outside RESP ignored.
REQ-031 timeout_err cleared only by reset.

Reset
REQ-032 rst_n low: state IDLE, rr_ptr 0, counter 0, operand/result/grant registers 0, all outputs 0, immediately (asynchronous).
REQ-033 Reset mid-operation abandons the operation; no rsp_valid issued afterwards; later core_out_valid ignored per REQ-026.
REQ-034 First requests after reset: requester 0 has priority when both valid.

Verification
REQ-035 Single request: req0 Px=1,Py=2,k=3; core model answers Rx=0xA,Ry=0xB 10 cycles after start -> core_in_valid one cycle at T+1 with 1/2/3, rsp_valid=01 at C+1 with 0xA/0xB, busy low after rsp_ready.
REQ-036 Contention: both req_valid high from reset -> req0 served first, then req1, then req0 again (rr alternation across 3 ops with both held high); req_ready never 11.
REQ-037 Backpressure: rsp_ready[0] low 5 cycles -> rsp_valid[0], rsp_Rx/Ry stable for 5 cycles, no new req_ready meanwhile.
REQ-038 Timeout: TIMEOUT=16, core silent -> rsp_valid with Rx=Ry=0 after 16 WAIT cycles, timeout_err=1 persisting through next good operation.
REQ-039 Reset in WAIT: rst_n low 2 cycles, then core_out_valid -> all outputs 0, no rsp_valid, next request processed normally.
